proc_run_controller: RTL
========================

# proc_run_controller

Synthesizable run controller for the single-cycle processor core. It replaces free-running bench timing with a sequenced core-reset pulse, a cycle budget, and a pass/fail detector on a memory-mapped "tohost" write. Because it is parametrised, the same block drives simulation benches and FPGA bring-up. It sits between the top-level clock/reset and the processor, and observes the core's data-memory write port and its `zero` flag.

## Interface
Parameters:
- `ADDR_W`, 32: width of the observed data-memory write address.
- `DATA_W`, 32: width of the observed write data.
- `CNT_W`, 32: width of the cycle and zero-event counters.
- `RST_CYCLES`, 2: cycles that `core_reset` is held high after `start`; must be ≥1.
- `MAX_CYCLES`, 20: run-cycle budget before timeout; must be ≥1 and < 2^CNT_W.
- `TOHOST_ADDR`, 32'h0000_0040: write address that ends the run.

Ports:
- `clock`, in, 1: single clock; all logic on the rising edge.
- `reset`, in, 1: synchronous, active-low reset of this block.
- `start`, in, 1: level-sampled request to begin a run; honoured only in IDLE or a terminal state.
- `core_reset`, out, 1: active-high reset to the processor.
- `mem_we`, in, 1: core data-memory write enable.
- `mem_addr`, in, ADDR_W: core data-memory write address.
- `mem_wdata`, in, DATA_W: core data-memory write data.
- `core_zero`, in, 1: core ALU zero flag.
- `running`, out, 1: high while in RUN.
- `done`, out, 1: high in PASS, FAIL or TIMEOUT.
- `status`, out, 2: 0 = none/running, 1 = pass, 2 = fail, 3 = timeout.
- `fail_code`, out, DATA_W: tohost data captured on FAIL, otherwise 0.
- `cycle_count`, out, CNT_W: RUN cycles elapsed.
- `zero_count`, out, CNT_W: RUN cycles with `core_zero` high.

## Operation
- States: IDLE, CRST, RUN, PASS, FAIL, TIMEOUT.
- `reset` low at an edge: state goes to IDLE, `core_reset`=1, all counters and `fail_code` go to 0, `status`=0, `running`=0, `done`=0. This holds regardless of the current state, including mid-run.
- IDLE: `core_reset`=1. On `start`=1, go to CRST with the reset counter at 0.
- CRST: `core_reset`=1. Count RST_CYCLES cycles, then go to RUN. On entry, clear `cycle_count`, `zero_count`, `fail_code` and `status`.
- RUN: `core_reset`=0 and `running`=1.
  - Each cycle, `cycle_count` increments.
  - `zero_count` increments when `core_zero`=1.
  - Exit priority, evaluated on the current cycle's inputs:
    1. `mem_we`=1 and `mem_addr`==TOHOST_ADDR: if `mem_wdata`==1 go to PASS, otherwise go to FAIL and capture `fail_code`=`mem_wdata`.
    2. Otherwise, if `cycle_count`==MAX_CYCLES-1, go to TIMEOUT.
  - The counter increment still occurs on the exit cycle, so `cycle_count` in a terminal state equals the number of RUN cycles executed.
- Terminal states: `core_reset`=1 and `done`=1; counters freeze. `start`=1 re-enters CRST, which restarts the run and clears the results.
- `start` in CRST or RUN is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap. The MAX_CYCLES constraint keeps `cycle_count` from saturating in a legal configuration.
- Writes to any address other than TOHOST_ADDR are ignored.

## Timing
- All outputs are registered and decoded from state or registers; there are no combinational paths from inputs to outputs.
- A `start` sampled at edge N puts the block in CRST after edge N.
  - `core_reset` stays high for RST_CYCLES full cycles.
  - `running` rises after edge N+RST_CYCLES.
- A tohost write sampled at edge M produces `done`/`status` after edge M. `running` falls on the same edge.
- Timeout with no write: `done` rises after exactly MAX_CYCLES RUN cycles, with `cycle_count`=MAX_CYCLES.
- If a tohost write and the timeout condition occur in the same cycle, PASS/FAIL wins.
- Reset is asserted with the same timing in every state: `reset` low at edge K puts every output at its reset value after edge K.

## Test plan
- Reset and default start: hold `reset` low for 2 cycles -> `core_reset`=1, `done`=0, counts 0. Then pulse `start` -> `core_reset` high for 2 cycles, then `running`=1.
- Pass: in RUN cycle 7, write 1 to 0x40 -> `status`=1, `done`=1, `cycle_count`=7 (RUN cycles 1..7 counted), `core_reset`=1.
- Fail plus counters: drive `core_zero`=1 on 3 RUN cycles, then write 0x0000_0005 to 0x40 -> `status`=2, `fail_code`=5, `zero_count`=3.
- Timeout: no writes with MAX_CYCLES=20 -> `status`=3 after 20 RUN cycles and `cycle_count`=20. A tohost write in cycle 20 instead -> PASS, not TIMEOUT.
- Decoy and restart: writing 1 to 0x44 has no effect. After FAIL, `start` -> counters and `fail_code` clear and a new CRST/RUN sequence begins.
- Mid-run reset: `reset` low in RUN cycle 5 -> IDLE, all outputs at their reset values on the next cycle. A subsequent `start` runs normally.

Source files
------------

// File: rtl/proc_run_controller.sv
// Run controller for the single-cycle core: sequences the core reset, enforces a
// cycle budget and detects pass/fail from a write to the tohost address.
module proc_run_controller #(
    parameter int              ADDR_W      = 32,
    parameter int              DATA_W      = 32,
    parameter int              CNT_W       = 32,
    parameter int              RST_CYCLES  = 2,
    parameter int              MAX_CYCLES  = 20,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_0040
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              core_reset,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              core_zero,
    output logic              running,
    output logic              done,
    output logic [1:0]        status,
    output logic [DATA_W-1:0] fail_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  zero_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CRST    = 3'd1,
        ST_RUN     = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    localparam int                RST_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CYC_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    state_t              state_r;
    state_t              next_state_s;
    logic [RST_W-1:0]    rst_cnt_r;
    logic [CNT_W-1:0]    cycle_count_r;
    logic [CNT_W-1:0]    zero_count_r;
    logic [DATA_W-1:0]   fail_code_r;
    logic                tohost_hit_s;
    logic                enter_crst_s;

    // Tohost write detection and CRST entry strobe
    always_comb begin
        tohost_hit_s = mem_we && (mem_addr == TOHOST_ADDR);
        enter_crst_s = (next_state_s == ST_CRST) && (state_r != ST_CRST);
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a tohost write outranks the timeout on the same cycle
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_CRST;
                else       next_state_s = ST_IDLE;
            end
            ST_CRST: begin
                if (rst_cnt_r == RST_LAST) next_state_s = ST_RUN;
                else                       next_state_s = ST_CRST;
            end
            ST_RUN: begin
                if (tohost_hit_s) begin
                    if (mem_wdata == DATA_W'(1)) next_state_s = ST_PASS;
                    else                         next_state_s = ST_FAIL;
                end else if (cycle_count_r == CYC_LAST) begin
                    next_state_s = ST_TIMEOUT;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                if (start) next_state_s = ST_CRST;
                else       next_state_s = state_r;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the state register only
    always_comb begin
        core_reset = 1'b1;
        running    = 1'b0;
        done       = 1'b0;
        status     = 2'd0;
        case (state_r)
            ST_RUN: begin
                core_reset = 1'b0;
                running    = 1'b1;
            end
            ST_PASS: begin
                done   = 1'b1;
                status = 2'd1;
            end
            ST_FAIL: begin
                done   = 1'b1;
                status = 2'd2;
            end
            ST_TIMEOUT: begin
                done   = 1'b1;
                status = 2'd3;
            end
            default: begin
                core_reset = 1'b1;
                running    = 1'b0;
            end
        endcase
    end

    // Core-reset hold counter, active only in CRST
    always_ff @(posedge clock) begin
        if (!reset) begin
            rst_cnt_r <= '0;
        end else if (state_r != ST_CRST) begin
            rst_cnt_r <= '0;
        end else if (rst_cnt_r != RST_LAST) begin
            rst_cnt_r <= rst_cnt_r + RST_W'(1);
        end else begin
            rst_cnt_r <= rst_cnt_r;
        end
    end

    // Saturating run counters, cleared on CRST entry and frozen outside RUN
    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_count_r <= '0;
            zero_count_r  <= '0;
        end else if (enter_crst_s) begin
            cycle_count_r <= '0;
            zero_count_r  <= '0;
        end else if (state_r == ST_RUN) begin
            if (cycle_count_r != CNT_MAX) cycle_count_r <= cycle_count_r + CNT_W'(1);
            else                          cycle_count_r <= cycle_count_r;
            if (core_zero && (zero_count_r != CNT_MAX)) zero_count_r <= zero_count_r + CNT_W'(1);
            else                                        zero_count_r <= zero_count_r;
        end else begin
            cycle_count_r <= cycle_count_r;
            zero_count_r  <= zero_count_r;
        end
    end

    // Fail code capture on the RUN -> FAIL transition
    always_ff @(posedge clock) begin
        if (!reset) begin
            fail_code_r <= '0;
        end else if (enter_crst_s) begin
            fail_code_r <= '0;
        end else if ((state_r == ST_RUN) && (next_state_s == ST_FAIL)) begin
            fail_code_r <= mem_wdata;
        end else begin
            fail_code_r <= fail_code_r;
        end
    end

    assign cycle_count = cycle_count_r;
    assign zero_count  = zero_count_r;
    assign fail_code   = fail_code_r;

endmodule
